// File: rtl/ex_mem_if.sv
// ex_mem_if: EX->MEM pipeline register bus.
//   EX side   : ex_valid, alu_result, zero_flag, store_data, branch_target,
//               write_reg, reg_write, mem_read, mem_write, mem_to_reg,
//               branch, branch_ne
//   MEM side  : mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
//               mem_mem_to_reg, mem_alu_result, mem_store_data,
//               mem_branch_target, mem_write_reg, pc_src,
//               instr_count, taken_count
// The slave modport is the pipeline register itself; master is whoever
// drives EX and observes MEM (the core, or a bench).
interface ex_mem_if;
  logic        ex_valid;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic [31:0] store_data;
  logic [31:0] branch_target;
  logic [4:0]  write_reg;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        branch;
  logic        branch_ne;

  logic        mem_valid;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic        mem_mem_to_reg;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_store_data;
  logic [31:0] mem_branch_target;
  logic [4:0]  mem_write_reg;
  logic        pc_src;
  logic [31:0] instr_count;
  logic [15:0] taken_count;

  modport slave (
    input  ex_valid, alu_result, zero_flag, store_data, branch_target,
           write_reg, reg_write, mem_read, mem_write, mem_to_reg,
           branch, branch_ne,
    output mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
           mem_mem_to_reg, mem_alu_result, mem_store_data,
           mem_branch_target, mem_write_reg, pc_src,
           instr_count, taken_count
  );

  modport master (
    output ex_valid, alu_result, zero_flag, store_data, branch_target,
           write_reg, reg_write, mem_read, mem_write, mem_to_reg,
           branch, branch_ne,
    input  mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
           mem_mem_to_reg, mem_alu_result, mem_store_data,
           mem_branch_target, mem_write_reg, pc_src,
           instr_count, taken_count
  );
endinterface

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with branch resolution and
// instruction / taken-branch counters.
//   clock : system clock, rising edge
//   reset : synchronous active-high reset (clears every output)
//   stall : hold all state
//   flush : turn the MEM slot into a bubble (controls cleared, data kept)
//   bus   : ex_mem_if.slave, EX inputs in, registered MEM outputs out
// Edge priority: reset > flush > stall > load. All outputs come straight
// from flops.
module ex_mem_reg (
  input  logic         clock,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  ex_mem_if.slave      bus
);

  logic        valid_q,  valid_d;
  logic        rw_q,     rw_d;
  logic        mr_q,     mr_d;
  logic        mw_q,     mw_d;
  logic        mtr_q,    mtr_d;
  logic        pc_src_q, pc_src_d;
  logic [31:0] alu_q,    alu_d;
  logic [31:0] sd_q,     sd_d;
  logic [31:0] bt_q,     bt_d;
  logic [4:0]  wr_q,     wr_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic [15:0] taken_count_q, taken_count_d;

  logic taken;

  // beq takes on zero, bne on non-zero; bubbles never take.
  assign taken = bus.ex_valid & bus.branch & (bus.zero_flag ^ bus.branch_ne);

  always_comb begin
    valid_d       = valid_q;
    rw_d          = rw_q;
    mr_d          = mr_q;
    mw_d          = mw_q;
    mtr_d         = mtr_q;
    pc_src_d      = pc_src_q;
    alu_d         = alu_q;
    sd_d          = sd_q;
    bt_d          = bt_q;
    wr_d          = wr_q;
    instr_count_d = instr_count_q;
    taken_count_d = taken_count_q;

    if (flush) begin
      // Data fields keep their old contents; only the slot is invalidated.
      valid_d  = 1'b0;
      rw_d     = 1'b0;
      mr_d     = 1'b0;
      mw_d     = 1'b0;
      mtr_d    = 1'b0;
      pc_src_d = 1'b0;
    end else if (!stall) begin
      valid_d  = bus.ex_valid;
      rw_d     = bus.ex_valid & bus.reg_write;
      mr_d     = bus.ex_valid & bus.mem_read;
      mw_d     = bus.ex_valid & bus.mem_write;
      mtr_d    = bus.ex_valid & bus.mem_to_reg;
      pc_src_d = taken;
      alu_d    = bus.alu_result;
      sd_d     = bus.store_data;
      bt_d     = bus.branch_target;
      wr_d     = bus.write_reg;
      if (bus.ex_valid)
        instr_count_d = instr_count_q + 32'd1;
      if (taken && (taken_count_q != 16'hFFFF))
        taken_count_d = taken_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q       <= 1'b0;
      rw_q          <= 1'b0;
      mr_q          <= 1'b0;
      mw_q          <= 1'b0;
      mtr_q         <= 1'b0;
      pc_src_q      <= 1'b0;
      alu_q         <= 32'd0;
      sd_q          <= 32'd0;
      bt_q          <= 32'd0;
      wr_q          <= 5'd0;
      instr_count_q <= 32'd0;
      taken_count_q <= 16'd0;
    end else begin
      valid_q       <= valid_d;
      rw_q          <= rw_d;
      mr_q          <= mr_d;
      mw_q          <= mw_d;
      mtr_q         <= mtr_d;
      pc_src_q      <= pc_src_d;
      alu_q         <= alu_d;
      sd_q          <= sd_d;
      bt_q          <= bt_d;
      wr_q          <= wr_d;
      instr_count_q <= instr_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign bus.mem_valid         = valid_q;
  assign bus.mem_reg_write     = rw_q;
  assign bus.mem_mem_read      = mr_q;
  assign bus.mem_mem_write     = mw_q;
  assign bus.mem_mem_to_reg    = mtr_q;
  assign bus.pc_src            = pc_src_q;
  assign bus.mem_alu_result    = alu_q;
  assign bus.mem_store_data    = sd_q;
  assign bus.mem_branch_target = bt_q;
  assign bus.mem_write_reg     = wr_q;
  assign bus.instr_count       = instr_count_q;
  assign bus.taken_count       = taken_count_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed bench for ex_mem_reg with a per-cycle reference
// model plus literal checkpoints.
module tb_ex_mem_reg;
  logic clock = 1'b0;
  logic reset, stall, flush;
  int   checks = 0;
  int   errors = 0;

  ex_mem_if bus ();

  ex_mem_reg dut (
    .clock (clock),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Reference state of what the MEM side must show.
  logic        m_valid, m_rw, m_mr, m_mw, m_mtr, m_pc;
  logic [31:0] m_alu, m_sd, m_bt, m_ic;
  logic [4:0]  m_wr;
  logic [15:0] m_tc;
  bit          m_started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      {m_valid, m_rw, m_mr, m_mw, m_mtr, m_pc} = '0;
      m_alu = 0; m_sd = 0; m_bt = 0; m_wr = 0; m_ic = 0; m_tc = 0;
      m_started = 1;
    end else if (flush) begin
      {m_valid, m_rw, m_mr, m_mw, m_mtr, m_pc} = '0;
    end else if (!stall) begin
      bit tk;
      tk = bus.ex_valid && bus.branch &&
           (bus.branch_ne ? !bus.zero_flag : bus.zero_flag);
      m_valid = bus.ex_valid;
      if (bus.ex_valid) begin
        m_rw = bus.reg_write; m_mr = bus.mem_read;
        m_mw = bus.mem_write; m_mtr = bus.mem_to_reg;
        m_ic = m_ic + 1;
      end else begin
        m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0;
      end
      m_pc  = tk;
      m_alu = bus.alu_result; m_sd = bus.store_data;
      m_bt  = bus.branch_target; m_wr = bus.write_reg;
      if (tk && m_tc < 16'hFFFF) m_tc = m_tc + 1;
    end
  end

  always @(negedge clock) begin
    if (m_started) begin
      chk("valid",  {31'd0, bus.mem_valid},      {31'd0, m_valid});
      chk("rw",     {31'd0, bus.mem_reg_write},  {31'd0, m_rw});
      chk("mr",     {31'd0, bus.mem_mem_read},   {31'd0, m_mr});
      chk("mw",     {31'd0, bus.mem_mem_write},  {31'd0, m_mw});
      chk("mtr",    {31'd0, bus.mem_mem_to_reg}, {31'd0, m_mtr});
      chk("pc_src", {31'd0, bus.pc_src},         {31'd0, m_pc});
      chk("alu",    bus.mem_alu_result,          m_alu);
      chk("sd",     bus.mem_store_data,          m_sd);
      chk("bt",     bus.mem_branch_target,       m_bt);
      chk("wr",     {27'd0, bus.mem_write_reg},  {27'd0, m_wr});
      chk("icnt",   bus.instr_count,             m_ic);
      chk("tcnt",   {16'd0, bus.taken_count},    {16'd0, m_tc});
    end
  end

  task automatic set_ex(input logic v, input logic [31:0] alu, input logic [4:0] wr,
                        input logic rw, input logic mr, input logic mw, input logic mtr,
                        input logic br, input logic bne, input logic zf);
    bus.ex_valid = v; bus.alu_result = alu; bus.write_reg = wr;
    bus.reg_write = rw; bus.mem_read = mr; bus.mem_write = mw; bus.mem_to_reg = mtr;
    bus.branch = br; bus.branch_ne = bne; bus.zero_flag = zf;
    bus.store_data = alu ^ 32'hA5A5_0000;
    bus.branch_target = alu + 32'h100;
  endtask

  // Advance one edge; return at the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    set_ex(1, 32'h1234_5678, 5'd9, 1, 1, 1, 1, 1, 0, 1);
    @(negedge clock);
    tick();
    chk("rst_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_alu",   bus.mem_alu_result, 32'd0);
    chk("rst_icnt",  bus.instr_count, 32'd0);

    reset = 0;
    set_ex(1, 32'h0000_0010, 5'd5, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("ld_alu",   bus.mem_alu_result, 32'h10);
    chk("ld_wr",    {27'd0, bus.mem_write_reg}, 32'd5);
    chk("ld_rw",    {31'd0, bus.mem_reg_write}, 32'd1);
    chk("ld_valid", {31'd0, bus.mem_valid}, 32'd1);
    chk("ld_icnt",  bus.instr_count, 32'd1);

    set_ex(1, 32'h20, 5'd0, 0, 0, 0, 0, 1, 0, 1);   // beq, zero -> taken
    tick();
    chk("beq_z_pc", {31'd0, bus.pc_src}, 32'd1);
    chk("beq_z_tc", {16'd0, bus.taken_count}, 32'd1);
    set_ex(1, 32'h24, 5'd0, 0, 0, 0, 0, 1, 1, 1);   // bne, zero -> not taken
    tick();
    chk("bne_z_pc", {31'd0, bus.pc_src}, 32'd0);
    set_ex(1, 32'h28, 5'd0, 0, 0, 0, 0, 1, 1, 0);   // bne, nonzero -> taken
    tick();
    chk("bne_nz_pc", {31'd0, bus.pc_src}, 32'd1);
    chk("bne_nz_tc", {16'd0, bus.taken_count}, 32'd2);
    set_ex(1, 32'h2C, 5'd3, 1, 0, 0, 0, 0, 1, 1);   // not a branch
    tick();
    chk("nobr_pc", {31'd0, bus.pc_src}, 32'd0);

    set_ex(1, 32'hDEAD_BEEF, 5'd17, 1, 1, 0, 1, 0, 0, 0);
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_ex(1, 32'h1000 + i, 5'd1, 0, 0, 1, 0, 1, 0, 1);
      tick();
      chk("stall_alu", bus.mem_alu_result, 32'hDEAD_BEEF);
      chk("stall_icnt", bus.instr_count, 32'd6);
    end
    flush = 1;
    tick();
    chk("sf_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("sf_ctl", {28'd0, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_to_reg, bus.pc_src}, 32'd0);
    chk("sf_alu", bus.mem_alu_result, 32'hDEAD_BEEF);
    chk("sf_icnt", bus.instr_count, 32'd6);
    chk("sf_tcnt", {16'd0, bus.taken_count}, 32'd2);
    stall = 0; flush = 0;

    set_ex(0, 32'h55, 5'd2, 1, 0, 1, 0, 1, 0, 1);   // bubble
    tick();
    chk("bub_mw", {31'd0, bus.mem_mem_write}, 32'd0);
    chk("bub_pc", {31'd0, bus.pc_src}, 32'd0);
    chk("bub_icnt", bus.instr_count, 32'd6);

    reset = 1; stall = 1; flush = 1;
    set_ex(1, 32'h77, 5'd7, 1, 1, 1, 1, 1, 0, 1);
    tick();
    chk("rmid_pc", {31'd0, bus.pc_src}, 32'd0);
    chk("rmid_alu", bus.mem_alu_result, 32'd0);
    chk("rmid_tcnt", {16'd0, bus.taken_count}, 32'd0);
    reset = 0; stall = 0; flush = 0;
    tick();
    chk("post_pc", {31'd0, bus.pc_src}, 32'd1);
    chk("post_alu", bus.mem_alu_result, 32'h77);
    chk("post_icnt", bus.instr_count, 32'd1);

    // Saturation: 65534 more taken branches reach 0xFFFF, then one extra.
    set_ex(1, 32'h300, 5'd4, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_reach", {16'd0, bus.taken_count}, 32'h0000_FFFF);
    tick();
    chk("sat_hold", {16'd0, bus.taken_count}, 32'h0000_FFFF);

    // Wrap: preset the instruction counter, then one valid load.
    stall = 1;
    tick();
    dut.instr_count_q = 32'hFFFF_FFFF;
    m_ic = 32'hFFFF_FFFF;
    stall = 0;
    set_ex(1, 32'h400, 5'd6, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("wrap_icnt", bus.instr_count, 32'd0);
    tick();
    chk("wrap_next", bus.instr_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
